// File: rtl/text_scanout_pkg.sv
// Shared text-mode definitions: screen geometry, VRAM address layout and the
// beam record carried down the scanout pipeline.
package text_pkg;

  localparam int unsigned COLS   = 80;
  localparam int unsigned ROWS   = 30;
  localparam int unsigned CELL_W = 8;
  localparam int unsigned CELL_H = 16;

  typedef logic [15:0] vram_addr_t;
  typedef logic [6:0]  col_t;
  typedef logic [4:0]  row_t;
  typedef logic [11:0] rgb_t;

  // Beam coordinates and timing flags as they travel through the pipeline.
  typedef struct packed {
    logic [2:0] px;
    logic [3:0] gr;
    logic       de;
    logic       hs;
    logic       vs;
    col_t       col;
    row_t       row;
  } beam_t;

  // Idle beam: blank pixel with both syncs deasserted (active-low).
  localparam beam_t BEAM_IDLE = '{px: 3'd0, gr: 4'd0, de: 1'b0, hs: 1'b1,
                                  vs: 1'b1, col: 7'd0, row: 5'd0};

  // VRAM address layout shared with the write-side engines.
  function automatic vram_addr_t text_addr(input row_t row, input col_t col);
    return {4'b0000, row, col};
  endfunction

endpackage

// File: rtl/text_scanout_if.sv
// VRAM read port and font-ROM port used by the text scanout.
interface text_scanout_if;
  import text_pkg::*;

  vram_addr_t  raddr;
  logic [7:0]  rdata;
  logic [11:0] font_addr;
  logic [7:0]  font_data;

  modport master (
    output raddr,
    output font_addr,
    input  rdata,
    input  font_data
  );

  modport slave (
    input  raddr,
    input  font_addr,
    output rdata,
    output font_data
  );

endinterface

// File: rtl/text_scanout_cursor_blink.sv
// Cursor latches and blink timer; everything updates only on the frame tick
// so the cursor is stable for a whole frame.
module cursor_blink
  import text_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic cursor_en,
  input  col_t cursor_x,
  input  row_t cursor_y,
  output logic cursor_on_l,
  output col_t cursor_x_l,
  output row_t cursor_y_l,
  output logic blink_phase
);

  localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

  logic [CW-1:0] r_frame_cnt;
  logic          r_blink_phase;
  logic          r_cursor_on;
  col_t          r_cursor_x;
  row_t          r_cursor_y;

  // Frame counter wraps after BLINK_FRAMES ticks and flips the blink phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (r_frame_cnt == LAST) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // Capture cursor controls once per frame to avoid mid-frame tearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cursor_on <= 1'b0;
      r_cursor_x  <= '0;
      r_cursor_y  <= '0;
    end else if (frame_tick) begin
      r_cursor_on <= cursor_en;
      r_cursor_x  <= cursor_x;
      r_cursor_y  <= cursor_y;
    end
  end

  assign cursor_on_l = r_cursor_on;
  assign cursor_x_l  = r_cursor_x;
  assign cursor_y_l  = r_cursor_y;
  assign blink_phase = r_blink_phase;

endmodule

// File: rtl/text_scanout.sv
// Text-mode scanout: beam position -> VRAM read -> font lookup -> RGB pixel,
// three registered stages with matching delay lines for the timing flags.
module text_scanout
  import text_pkg::*;
#(
  parameter int unsigned COLS         = text_pkg::COLS,
  parameter int unsigned ROWS         = text_pkg::ROWS,
  parameter logic [11:0] FG           = 12'hFFF,
  parameter logic [11:0] BG           = 12'h000,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            hcount,
  input  logic [9:0]            vcount,
  input  logic                  active,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  cursor_en,
  input  logic [6:0]            cursor_x,
  input  logic [4:0]            cursor_y,
  text_scanout_if.master        mem,
  output logic [11:0]           rgb,
  output logic                  de,
  output logic                  hsync_out,
  output logic                  vsync_out
);

  beam_t      w_beam;
  logic       w_frame_tick;

  beam_t      r_s1;
  beam_t      r_s2;
  vram_addr_t r_raddr;
  logic [11:0] r_font_addr;
  rgb_t       r_rgb;
  logic       r_de;
  logic       r_hs;
  logic       r_vs;

  logic       w_cursor_on_l;
  col_t       w_cursor_x_l;
  row_t       w_cursor_y_l;
  logic       w_blink_phase;

  logic       w_bit;
  logic       w_in_range;
  logic       w_cursor_valid;
  logic       w_cursor_hit;
  rgb_t       w_rgb;

  assign w_beam = '{px: hcount[2:0], gr: vcount[3:0], de: active,
                    hs: hsync_in, vs: vsync_in,
                    col: hcount[9:3], row: vcount[8:4]};

  assign w_frame_tick = (hcount == '0) && (vcount == '0);

  cursor_blink #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_cursor_blink (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (w_frame_tick),
    .cursor_en   (cursor_en),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .cursor_on_l (w_cursor_on_l),
    .cursor_x_l  (w_cursor_x_l),
    .cursor_y_l  (w_cursor_y_l),
    .blink_phase (w_blink_phase)
  );

  // S0: VRAM read address, issued every cycle including blanking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_raddr <= '0;
    end else begin
      r_raddr <= text_addr(w_beam.row, w_beam.col);
    end
  end

  // S1: font-ROM address from the returned character and its glyph row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_font_addr <= '0;
    end else begin
      r_font_addr <= {mem.rdata, r_s1.gr};
    end
  end

  // Beam delay lines; reset to blank with syncs deasserted so flushed
  // pipeline contents never reach the output as visible pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= BEAM_IDLE;
      r_s2 <= BEAM_IDLE;
    end else begin
      r_s1 <= w_beam;
      r_s2 <= r_s1;
    end
  end

  assign w_bit          = mem.font_data[3'd7 - r_s2.px];
  assign w_in_range     = (32'(r_s2.col) < COLS) && (32'(r_s2.row) < ROWS);
  assign w_cursor_valid = (32'(w_cursor_x_l) < COLS) && (32'(w_cursor_y_l) < ROWS);
  assign w_cursor_hit   = w_cursor_on_l && w_blink_phase && w_cursor_valid &&
                          (r_s2.col == w_cursor_x_l) && (r_s2.row == w_cursor_y_l) &&
                          (r_s2.gr[3:1] == 3'b111);

  // Pixel colour: blanking forces black, cells off-screen show background,
  // the underline cursor inverts the glyph bit on the last two glyph rows.
  always_comb begin
    w_rgb = BG;
    if (!r_s2.de) begin
      w_rgb = '0;
    end else if (!w_in_range) begin
      w_rgb = BG;
    end else if (w_bit ^ w_cursor_hit) begin
      w_rgb = FG;
    end
  end

  // S2: registered pixel and timing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb <= '0;
      r_de  <= 1'b0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
    end else begin
      r_rgb <= w_rgb;
      r_de  <= r_s2.de;
      r_hs  <= r_s2.hs;
      r_vs  <= r_s2.vs;
    end
  end

  assign mem.raddr     = r_raddr;
  assign mem.font_addr = r_font_addr;
  assign rgb           = r_rgb;
  assign de            = r_de;
  assign hsync_out     = r_hs;
  assign vsync_out     = r_vs;

endmodule

// File: tb/tb_text_scanout.sv
// Directed self-checking bench for text_scanout with behavioural VRAM/font models.
module tb_text_scanout;

  localparam logic [11:0] FGC = 12'hF80;
  localparam logic [11:0] BGC = 12'h00F;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        active;
  logic        hsync_in;
  logic        vsync_in;
  logic        cursor_en;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic [11:0] rgb;
  logic        de;
  logic        hsync_out;
  logic        vsync_out;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0] vram [0:4095];
  logic [7:0] font [0:4095];

  logic [9:0] s_h   [6] = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5};
  logic       s_act [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic       s_hs  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       s_vs  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  text_scanout_if mem ();

  assign mem.rdata     = vram[mem.raddr[11:0]];
  assign mem.font_data = font[mem.font_addr];

  text_scanout #(
    .COLS         (80),
    .ROWS         (30),
    .FG           (FGC),
    .BG           (BGC),
    .BLINK_FRAMES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hcount    (hcount),
    .vcount    (vcount),
    .active    (active),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .cursor_en (cursor_en),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .mem       (mem),
    .rgb       (rgb),
    .de        (de),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic a,
                       input logic hs, input logic vs);
    hcount   = h;
    vcount   = v;
    active   = a;
    hsync_in = hs;
    vsync_in = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
  endtask

  // Eight pixels of one glyph row, then two blank cycles to drain; output for
  // pixel k appears after the third edge following its input.
  task automatic run_row(input string tag, input logic [9:0] h0, input logic [9:0] v,
                         input logic a, input logic [7:0] bits);
    logic [11:0] exp_rgb;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(h0 + 10'(i), v, a, 1'b1, 1'b1);
      else       drive(10'd700, v, 1'b0, 1'b1, 1'b1);
      if (i >= 2) begin
        exp_rgb = !a ? 12'h000 : (bits[9 - i] ? FGC : BGC);
        chk({tag, "_rgb"}, {4'h0, rgb}, {4'h0, exp_rgb});
        chk({tag, "_de"}, {15'h0, de}, {15'h0, a});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      vram[i] = 8'h20;
      font[i] = 8'h00;
    end
    vram[261]  = 8'h41;   // row 2, col 5
    vram[131]  = 8'hFF;   // row 1, col 3
    vram[208]  = 8'hFF;   // row 1, col 80 (off-screen)
    vram[3843] = 8'hFF;   // row 30, col 3 (off-screen)
    vram[3791] = 8'hFF;   // row 29, col 79
    vram[522]  = 8'h42;   // row 4, col 10
    font[12'h413] = 8'h18;
    font[12'h42D] = 8'h3C;
    font[12'h42E] = 8'hF0;
    font[12'h42F] = 8'h81;
    for (int i = 0; i < 16; i++) font[12'hFF0 + i] = 8'hFF;

    // Reset state with syncs driven low at the input
    rst = 1'b1;
    cursor_en = 1'b0; cursor_x = 7'd0; cursor_y = 5'd0;
    drive(10'd100, 10'd100, 1'b1, 1'b0, 1'b0);
    drive(10'd101, 10'd100, 1'b1, 1'b0, 1'b0);
    drive(10'd102, 10'd100, 1'b1, 1'b0, 1'b0);
    chk("rst_raddr", mem.raddr, 16'h0000);
    chk("rst_font_addr", {4'h0, mem.font_addr}, 16'h0000);
    chk("rst_rgb", {4'h0, rgb}, 16'h0000);
    chk("rst_de", {15'h0, de}, 16'h0000);
    chk("rst_hsync", {15'h0, hsync_out}, 16'h0001);
    chk("rst_vsync", {15'h0, vsync_out}, 16'h0001);
    rst = 1'b0;
    drive(10'd700, 10'd100, 1'b0, 1'b1, 1'b1);
    drive(10'd700, 10'd100, 1'b0, 1'b1, 1'b1);
    drive(10'd700, 10'd100, 1'b0, 1'b1, 1'b1);

    // 'A' at row 2 col 5: address path then the rendered row
    drive(10'd40, 10'd35, 1'b1, 1'b1, 1'b1);
    chk("A_raddr", mem.raddr, 16'h0105);
    drive(10'd41, 10'd35, 1'b1, 1'b1, 1'b1);
    chk("A_font_addr", {4'h0, mem.font_addr}, 16'h0413);
    drive(10'd700, 10'd35, 1'b0, 1'b1, 1'b1);
    drive(10'd700, 10'd35, 1'b0, 1'b1, 1'b1);
    run_row("A_row3", 10'd40, 10'd35, 1'b1, 8'h18);

    // Origin pixel and 3-clock sync/de alignment
    for (int i = 0; i < 6; i++) begin
      drive(s_h[i], 10'd0, s_act[i], s_hs[i], s_vs[i]);
      if (i == 0) chk("org_raddr", mem.raddr, 16'h0000);
      if (i >= 2) begin
        chk("sync_h", {15'h0, hsync_out}, {15'h0, s_hs[i-2]});
        chk("sync_v", {15'h0, vsync_out}, {15'h0, s_vs[i-2]});
        chk("org_de", {15'h0, de}, {15'h0, s_act[i-2]});
        chk("org_rgb", {4'h0, rgb}, {4'h0, (s_act[i-2] ? BGC : 12'h000)});
      end else begin
        chk("org_de_early", {15'h0, de}, 16'h0000);
        chk("sync_h_early", {15'h0, hsync_out}, 16'h0001);
      end
    end
    drive(10'd700, 10'd1, 1'b0, 1'b1, 1'b1);
    drive(10'd700, 10'd1, 1'b0, 1'b1, 1'b1);

    // Blanking over an all-ones glyph, then visible, then screen boundaries
    run_row("blank", 10'd24, 10'd16, 1'b0, 8'h00);
    run_row("ones", 10'd24, 10'd16, 1'b1, 8'hFF);
    run_row("col80", 10'd640, 10'd16, 1'b1, 8'h00);
    run_row("row30", 10'd24, 10'd480, 1'b1, 8'h00);
    run_row("r29c79", 10'd632, 10'd464, 1'b1, 8'hFF);

    // Asynchronous reset mid-line
    drive(10'd24, 10'd16, 1'b1, 1'b0, 1'b0);
    drive(10'd25, 10'd16, 1'b1, 1'b0, 1'b0);
    drive(10'd26, 10'd16, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_rgb", {4'h0, rgb}, {4'h0, FGC});
    chk("pre_rst_hs", {15'h0, hsync_out}, 16'h0000);
    rst = 1'b1;
    #1;
    chk("arst_rgb", {4'h0, rgb}, 16'h0000);
    chk("arst_de", {15'h0, de}, 16'h0000);
    chk("arst_hs", {15'h0, hsync_out}, 16'h0001);
    chk("arst_vs", {15'h0, vsync_out}, 16'h0001);
    drive(10'd700, 10'd16, 1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    drive(10'd700, 10'd16, 1'b0, 1'b1, 1'b1);
    drive(10'd700, 10'd16, 1'b0, 1'b1, 1'b1);
    chk("post_rst_idle_de", {15'h0, de}, 16'h0000);
    drive(10'd24, 10'd16, 1'b1, 1'b1, 1'b1);
    chk("post_rst_de0", {15'h0, de}, 16'h0000);
    drive(10'd25, 10'd16, 1'b1, 1'b1, 1'b1);
    chk("post_rst_de1", {15'h0, de}, 16'h0000);
    drive(10'd26, 10'd16, 1'b1, 1'b1, 1'b1);
    chk("post_rst_de2", {15'h0, de}, 16'h0001);
    chk("post_rst_rgb", {4'h0, rgb}, {4'h0, FGC});
    drive(10'd700, 10'd16, 1'b0, 1'b1, 1'b1);
    drive(10'd700, 10'd16, 1'b0, 1'b1, 1'b1);

    // Cursor at (10,4), blink period 2 ticks; counter starts clean from reset
    cursor_en = 1'b1; cursor_x = 7'd10; cursor_y = 5'd4;
    run_row("cur_f0", 10'd80, 10'd78, 1'b1, 8'hF0);
    tick();
    run_row("cur_f1", 10'd80, 10'd78, 1'b1, 8'hF0);
    tick();
    run_row("cur_f2_g14", 10'd80, 10'd78, 1'b1, 8'h0F);
    run_row("cur_f2_g15", 10'd80, 10'd79, 1'b1, 8'h7E);
    run_row("cur_f2_g13", 10'd80, 10'd77, 1'b1, 8'h3C);
    run_row("cur_f2_c11", 10'd88, 10'd78, 1'b1, 8'h00);
    cursor_x = 7'd11;
    run_row("cur_f2_mid10", 10'd80, 10'd78, 1'b1, 8'h0F);
    run_row("cur_f2_mid11", 10'd88, 10'd78, 1'b1, 8'h00);
    tick();
    run_row("cur_f3_c10", 10'd80, 10'd78, 1'b1, 8'hF0);
    run_row("cur_f3_c11", 10'd88, 10'd78, 1'b1, 8'hFF);
    run_row("cur_f3_c11g15", 10'd88, 10'd79, 1'b1, 8'hFF);
    tick();
    run_row("cur_f4_off", 10'd88, 10'd78, 1'b1, 8'h00);
    cursor_x = 7'd10;
    tick();
    run_row("cur_f5_off", 10'd80, 10'd78, 1'b1, 8'hF0);
    tick();
    run_row("cur_f6_c10", 10'd80, 10'd78, 1'b1, 8'h0F);
    run_row("cur_f6_c11", 10'd88, 10'd78, 1'b1, 8'h00);
    cursor_x = 7'd100;
    tick();
    run_row("cur_f7_c10", 10'd80, 10'd78, 1'b1, 8'hF0);
    run_row("cur_f7_c11", 10'd88, 10'd78, 1'b1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/text_scanout.md
# text_scanout

Read-side counterpart of the VRAM text-buffer writers. Converts VGA beam coordinates into VRAM character reads and font-ROM glyph lookups, then emits one RGB pixel per clock. Also draws a blinking underline cursor. It sits between the VGA timing generator and the DAC/output registers. It uses the VRAM read port, where the clear engine and CPU path use the write port.

## Interface
Parameters:
- COLS, 80: text columns (8-pixel cells)
- ROWS, 30: text rows (16-pixel cells)
- FG, 12'hFFF: foreground RGB444
- BG, 12'h000: background RGB444
- BLINK_FRAMES, 30: frames per cursor blink phase

Ports:
- clk  in  1  pixel clock; the only clock
- rst  in  1  asynchronous, active-high reset
- hcount  in  10  beam x from timing generator
- vcount  in  10  beam y from timing generator
- active  in  1  visible-region flag, aligned with hcount/vcount
- hsync_in  in  1  active-low hsync, aligned with hcount
- vsync_in  in  1  active-low vsync, aligned with hcount
- cursor_en  in  1  cursor enable
- cursor_x  in  7  cursor column
- cursor_y  in  5  cursor row
- raddr  out  16  VRAM read address {4'b0000, row[4:0], col[6:0]}; same layout as the write port
- rdata  in  8  VRAM character code; valid 1 cycle after raddr
- font_addr  out  12  {char[7:0], glyph_row[3:0]}
- font_data  in  8  glyph row bits, MSB = leftmost pixel; valid 1 cycle after font_addr
- rgb  out  12  pixel colour
- de  out  1  data enable (delayed active)
- hsync_out  out  1  delayed hsync_in
- vsync_out  out  1  delayed vsync_in

## Operation
- Coordinates: col = hcount[9:3], row = vcount[8:4], px = hcount[2:0], gr = vcount[3:0].
- Three-stage pipeline:
  - S0: raddr is registered from col/row.
  - S1: font_addr = {rdata, gr_d1}, registered.
  - S2: rgb is registered from font_data bit (7 − px_d2), with the cursor applied.
- px, gr, active, hsync, vsync, col and row are carried down delay lines that match each stage.
- Pixel value:
  - rgb = FG if the bit is 1, otherwise BG.
  - If de_d is 0, rgb is forced to 12'h000.
  - If col ≥ COLS or row ≥ ROWS, rgb is BG, whatever rdata contains.
- Cursor:
  - Visible when cursor_en_l = 1, blink_phase = 1, col_d = cursor_x_l, row_d = cursor_y_l, and gr_d ∈ {14, 15}.
  - Where visible, the glyph bit is inverted.
  - A cursor_x_l/cursor_y_l outside COLS/ROWS never matches, so no cursor is drawn.
- Frame tick: one cycle when hcount = 0 and vcount = 0. On each tick:
  - cursor_en, cursor_x and cursor_y are latched into the *_l registers, so the cursor never tears mid-frame.
  - frame_cnt increments.
  - When frame_cnt = BLINK_FRAMES − 1, frame_cnt wraps to 0 and blink_phase toggles.
- Reads are issued every cycle, blanking included. The VRAM port is read-only and has no handshake.

## Timing
- Latency from hcount/active/sync inputs to rgb/de/sync outputs: exactly 3 clocks.
- All outputs are registered.
- Values during and immediately after reset:
  - raddr = 0, font_addr = 0
  - rgb = 0, de = 0
  - hsync_out = 1, vsync_out = 1
  - blink_phase = 0, frame_cnt = 0
  - cursor *_l = 0
- Pipeline contents flushed by reset are never output as de = 1. The delay lines reset to de = 0 and syncs = 1.
- Reset asserted mid-frame: outputs return to the reset values immediately (asynchronous). After release, valid pixels resume 3 clocks after the first active input.
- A frame tick in the same cycle as a cursor_x change latches the new value.
- The blink toggle and the cursor latch take effect from the first pixel of that frame.

## Structure
- Shared package text_pkg:
  - COLS, ROWS, CELL_W = 8, CELL_H = 16
  - vram_addr_t (16-bit)
  - function text_addr(row, col) returning {4'b0, row, col}; shared with the write-side engines so the layout stays identical.
- One sub-module, cursor_blink:
  - Contains frame_cnt, blink_phase and the cursor latches.
  - Inputs: frame_tick, cursor_*.
  - Outputs: cursor_on_l, cursor_x_l, cursor_y_l, blink_phase.
- Pipeline and delay lines stay in text_scanout.

## Test plan
- VRAM model returns 8'h41 at address {row=2, col=5}; font ROM row 3 of 'A' = 8'b0001_1000; beam at hcount = 40..47, vcount = 35 → font_addr = 12'h413 one clock after the S0 raddr of hcount = 40. Three clocks later rgb is BG,BG,BG,FG,FG,BG,BG,BG.
- hcount = 0, vcount = 0 with VRAM all 8'h20 and a blank glyph → raddr = 16'h0000; rgb = BG with de = 1 three clocks after active = 1; hsync_out/vsync_out are hsync_in/vsync_in delayed exactly 3 clocks.
- active = 0 during blanking with a glyph whose bits are all 1 → rgb = 12'h000 and de = 0.
- cursor_en = 1, cursor (10, 4), BLINK_FRAMES = 2 → no cursor in frames 0–1; frames 2–3 invert rows 14–15 of cell (10, 4) only (vcount 78–79, hcount 80–87).
- cursor_x changed mid-frame → the change appears only from the next frame tick; cursor_x = 100 → never drawn.
- rst asserted mid-line → rgb = 0, de = 0 and syncs = 1 the same cycle; first de = 1 comes exactly 3 clocks after active returns.
